// File: rtl/keypad_entry_controller.sv
// Keypad entry controller: debounces single-key codes from a keypad priority
// encoder and shifts accepted digits into an MM:SS time-entry register.
module keypad_entry_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd_in,
    input  logic       valid_in,
    input  logic       clear,
    input  logic       lock,
    output logic       enablen,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic [2:0] digit_count,
    output logic       digit_strobe,
    output logic       reject,
    output logic       entry_valid
);

    localparam int unsigned DIG_W   = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned NUM_W   = 3;
    localparam int unsigned MAX_DIG = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_WAIT_RELEASE,
        S_LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [DIG_W-1:0]   cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   rel_q, rel_d;
    logic [DIG_W-1:0]   min_tens_q, min_tens_d;
    logic [DIG_W-1:0]   min_units_q, min_units_d;
    logic [DIG_W-1:0]   sec_tens_q, sec_tens_d;
    logic [DIG_W-1:0]   sec_units_q, sec_units_d;
    logic [NUM_W-1:0]   count_q, count_d;
    logic               strobe_q, strobe_d;
    logic               reject_q, reject_d;
    logic               enablen_q, enablen_d;

    // Next-state, digit shift register and pulse generation
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        rel_d       = rel_q;
        min_tens_d  = min_tens_q;
        min_units_d = min_units_q;
        sec_tens_d  = sec_tens_q;
        sec_units_d = sec_units_q;
        count_d     = count_q;
        strobe_d    = 1'b0;
        reject_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid_in && (bcd_in <= DIG_W'(9))) begin
                    cand_d  = bcd_in;
                    cnt_d   = CNT_W'(1);
                    state_d = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (valid_in && (bcd_in == cand_q)) begin
                    if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        // Key accepted: capture if room, otherwise flag it
                        cnt_d   = '0;
                        rel_d   = '0;
                        state_d = S_WAIT_RELEASE;
                        if (count_q < NUM_W'(MAX_DIG)) begin
                            min_tens_d  = min_units_q;
                            min_units_d = sec_tens_q;
                            sec_tens_d  = sec_units_q;
                            sec_units_d = cand_q;
                            count_d     = count_q + NUM_W'(1);
                            strobe_d    = 1'b1;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_WAIT_RELEASE: begin
                if (valid_in) begin
                    rel_d = '0;
                end else if (rel_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    rel_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    rel_d = rel_q + CNT_W'(1);
                end
            end
            S_LOCKED: begin
                // Unlock waits for a release so a key held across unlock is ignored
                rel_d   = '0;
                state_d = S_WAIT_RELEASE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Lock abandons any debounce and freezes the entry
        if (lock) begin
            state_d     = S_LOCKED;
            cnt_d       = '0;
            rel_d       = '0;
            min_tens_d  = min_tens_q;
            min_units_d = min_units_q;
            sec_tens_d  = sec_tens_q;
            sec_units_d = sec_units_q;
            count_d     = count_q;
            strobe_d    = 1'b0;
            reject_d    = 1'b0;
        end

        // Clear wins over any acceptance in the same cycle
        if (clear) begin
            state_d     = lock ? S_LOCKED : S_IDLE;
            cnt_d       = '0;
            rel_d       = '0;
            min_tens_d  = '0;
            min_units_d = '0;
            sec_tens_d  = '0;
            sec_units_d = '0;
            count_d     = '0;
            strobe_d    = 1'b0;
            reject_d    = 1'b0;
        end

        enablen_d = (state_d == S_LOCKED);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            rel_q       <= '0;
            min_tens_q  <= '0;
            min_units_q <= '0;
            sec_tens_q  <= '0;
            sec_units_q <= '0;
            count_q     <= '0;
            strobe_q    <= 1'b0;
            reject_q    <= 1'b0;
            enablen_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            rel_q       <= rel_d;
            min_tens_q  <= min_tens_d;
            min_units_q <= min_units_d;
            sec_tens_q  <= sec_tens_d;
            sec_units_q <= sec_units_d;
            count_q     <= count_d;
            strobe_q    <= strobe_d;
            reject_q    <= reject_d;
            enablen_q   <= enablen_d;
        end
    end

    // Output mapping; entry_valid decodes the registered entry
    always_comb begin
        enablen      = enablen_q;
        min_tens     = min_tens_q;
        min_units    = min_units_q;
        sec_tens     = sec_tens_q;
        sec_units    = sec_units_q;
        digit_count  = count_q;
        digit_strobe = strobe_q;
        reject       = reject_q;
        entry_valid  = (count_q != '0) && (sec_tens_q <= DIG_W'(5));
    end

endmodule
